// File: rtl/writebacker.sv
// -----------------------------------------------------------------------------
// writebacker
//
// Purpose:
//   Retire / writeback stage sitting directly behind the executer. It accepts
//   one executed instruction per valid/ready handshake, drives the register
//   file write port, owns the architectural PC and counts retired
//   instructions. Loads park in LOAD_WAIT until the synchronous data memory
//   has produced its word, which is then sliced and extended per funct3.
//
// Parameters:
//   RESET_PC     PC value loaded while RST is high.
//   MEM_LATENCY  cycles from accept until MEMORY_OUT is valid (1..7).
//
// Ports:
//   CLK, RST          clock (rising edge) and asynchronous active-high reset
//   IN_VALID/IN_READY handshake with the executer; IN_READY = state is IDLE
//   EXEC_RD           ALU result (write data for non-loads)
//   JUMP_DEST         next PC computed by the executer
//   MEMORY_OUT        data-memory read word, sampled at the end of the wait
//   IN_RD_ADDR/IN_RD_WE   destination register and its write request
//   IN_IS_LOAD/IN_FUNCT3/IN_BYTE_SEL  load flag, width/sign and byte offset
//   WB_WE/WB_ADDR/WB_DATA register-file write port (WB_WE is a 1-cycle pulse)
//   PC                architectural PC
//   RETIRE            1-cycle pulse per retired instruction
//   LOAD_ERR          1-cycle pulse when a load carried an illegal funct3
//   RETIRE_COUNT      free-running retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module writebacker #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] EXEC_RD,
  input  logic [31:0] JUMP_DEST,
  input  logic [31:0] MEMORY_OUT,
  input  logic [4:0]  IN_RD_ADDR,
  input  logic        IN_RD_WE,
  input  logic        IN_IS_LOAD,
  input  logic [2:0]  IN_FUNCT3,
  input  logic [1:0]  IN_BYTE_SEL,
  output logic        WB_WE,
  output logic [4:0]  WB_ADDR,
  output logic [31:0] WB_DATA,
  output logic [31:0] PC,
  output logic        RETIRE,
  output logic        LOAD_ERR,
  output logic [31:0] RETIRE_COUNT
);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] LOAD_LAT = 3'(MEM_LATENCY);

  // Control state
  logic [0:0]  state_q, state_d;
  logic [2:0]  waitCnt_q, waitCnt_d;

  // Load instruction captured at accept so upstream may move on
  logic [4:0]  ldRdAddr_q, ldRdAddr_d;
  logic        ldRdWe_q, ldRdWe_d;
  logic [2:0]  ldFunct3_q, ldFunct3_d;
  logic [1:0]  ldByteSel_q, ldByteSel_d;
  logic [31:0] ldPc_q, ldPc_d;

  // Registered retire outputs
  logic        wbWe_q, wbWe_d;
  logic [4:0]  wbAddr_q, wbAddr_d;
  logic [31:0] wbData_q, wbData_d;
  logic [31:0] pc_q, pc_d;
  logic        retire_q, retire_d;
  logic        loadErr_q, loadErr_d;
  logic [31:0] retireCount_q, retireCount_d;

  // Load extraction
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue;
  logic        loadFunct3Ok;

  // Retire request assembled by the FSM, applied to the output registers
  logic        retireNow;
  logic        retireWe;
  logic        retireErr;
  logic [4:0]  retireAddr;
  logic [31:0] retireData;
  logic [31:0] retirePc;

  assign IN_READY = (state_q == ST_IDLE);

  // Slice the memory word using the captured byte offset. Halfwords only look
  // at the upper offset bit, so an odd offset silently rounds down instead of
  // trapping. Unknown funct3 values leave loadFunct3Ok low.
  always_comb begin
    loadByte     = MEMORY_OUT[{ldByteSel_q, 3'b000} +: 8];
    loadHalf     = MEMORY_OUT[{ldByteSel_q[1], 4'b0000} +: 16];
    loadValue    = MEMORY_OUT;
    loadFunct3Ok = 1'b1;
    case (ldFunct3_q)
      F3_LB:   loadValue = {{24{loadByte[7]}}, loadByte};
      F3_LBU:  loadValue = {24'd0, loadByte};
      F3_LH:   loadValue = {{16{loadHalf[15]}}, loadHalf};
      F3_LHU:  loadValue = {16'd0, loadHalf};
      F3_LW:   loadValue = MEMORY_OUT;
      default: loadFunct3Ok = 1'b0;
    endcase
  end

  // Handshake / load-wait sequencing. A non-load retires on the accept edge
  // itself, so the stage never leaves IDLE and sustains one retire per cycle.
  // A load records everything it needs and counts down; the edge at which the
  // counter reads 1 is the one where MEMORY_OUT is valid, and that same edge
  // retires the load and reopens the handshake.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    ldRdAddr_d  = ldRdAddr_q;
    ldRdWe_d    = ldRdWe_q;
    ldFunct3_d  = ldFunct3_q;
    ldByteSel_d = ldByteSel_q;
    ldPc_d      = ldPc_q;

    retireNow  = 1'b0;
    retireWe   = 1'b0;
    retireErr  = 1'b0;
    retireAddr = IN_RD_ADDR;
    retireData = EXEC_RD;
    retirePc   = JUMP_DEST;

    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          if (IN_IS_LOAD) begin
            state_d     = ST_LOAD_WAIT;
            waitCnt_d   = LOAD_LAT;
            ldRdAddr_d  = IN_RD_ADDR;
            ldRdWe_d    = IN_RD_WE;
            ldFunct3_d  = IN_FUNCT3;
            ldByteSel_d = IN_BYTE_SEL;
            ldPc_d      = JUMP_DEST;
          end else begin
            retireNow = 1'b1;
            retireWe  = IN_RD_WE && (IN_RD_ADDR != 5'd0);
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (waitCnt_q == 3'd1) begin
          state_d    = ST_IDLE;
          retireNow  = 1'b1;
          retireErr  = !loadFunct3Ok;
          retireWe   = ldRdWe_q && (ldRdAddr_q != 5'd0) && loadFunct3Ok;
          retireAddr = ldRdAddr_q;
          retireData = loadValue;
          retirePc   = ldPc_q;
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register next-state. Pulses fall back to 0 unless something
  // retires; the write address/data only move when a write actually happens,
  // so they hold their previous contents otherwise.
  always_comb begin
    wbWe_d        = retireWe;
    retire_d      = retireNow;
    loadErr_d     = retireErr;
    wbAddr_d      = retireWe ? retireAddr : wbAddr_q;
    wbData_d      = retireWe ? retireData : wbData_q;
    pc_d          = retireNow ? retirePc : pc_q;
    retireCount_d = retireNow ? (retireCount_q + 32'd1) : retireCount_q;
  end

  // All state, with asynchronous reset. Resetting mid-wait simply discards the
  // pending load because the state returns to IDLE and no retire is staged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      waitCnt_q     <= 3'd0;
      ldRdAddr_q    <= 5'd0;
      ldRdWe_q      <= 1'b0;
      ldFunct3_q    <= 3'd0;
      ldByteSel_q   <= 2'd0;
      ldPc_q        <= 32'd0;
      wbWe_q        <= 1'b0;
      wbAddr_q      <= 5'd0;
      wbData_q      <= 32'd0;
      pc_q          <= RESET_PC;
      retire_q      <= 1'b0;
      loadErr_q     <= 1'b0;
      retireCount_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      waitCnt_q     <= waitCnt_d;
      ldRdAddr_q    <= ldRdAddr_d;
      ldRdWe_q      <= ldRdWe_d;
      ldFunct3_q    <= ldFunct3_d;
      ldByteSel_q   <= ldByteSel_d;
      ldPc_q        <= ldPc_d;
      wbWe_q        <= wbWe_d;
      wbAddr_q      <= wbAddr_d;
      wbData_q      <= wbData_d;
      pc_q          <= pc_d;
      retire_q      <= retire_d;
      loadErr_q     <= loadErr_d;
      retireCount_q <= retireCount_d;
    end
  end

  assign WB_WE        = wbWe_q;
  assign WB_ADDR      = wbAddr_q;
  assign WB_DATA      = wbData_q;
  assign PC           = pc_q;
  assign RETIRE       = retire_q;
  assign LOAD_ERR     = loadErr_q;
  assign RETIRE_COUNT = retireCount_q;

endmodule

// File: tb/tb_writebacker.sv
// -----------------------------------------------------------------------------
// tb_writebacker
//
// Two writebacker instances share one clock: dut0 with a one-cycle memory
// latency and dut1 with a three-cycle latency. Expected results come from a
// small reference model (PC, retire count, last written address/data) and
// from arithmetic load extraction written straight from the load rules.
// -----------------------------------------------------------------------------
module tb_writebacker;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk;
  logic [1:0]       rst, inValid, inReady, inRdWe, inIsLoad, wbWe, retire, loadErr;
  logic [1:0][31:0] execRd, jumpDest, memoryOut, wbData, pc, retireCount;
  logic [1:0][4:0]  inRdAddr, wbAddr;
  logic [1:0][2:0]  inFunct3;
  logic [1:0][1:0]  inByteSel;

  // Reference model state per instance
  logic [31:0] mPc [2];
  logic [31:0] mCount [2];
  logic [31:0] mData [2];
  logic [4:0]  mAddr [2];

  int vectors = 0;
  int miscompares = 0;

  writebacker #(.RESET_PC(RST_PC), .MEM_LATENCY(LAT0)) dut0 (
    .CLK(clk), .RST(rst[0]), .IN_VALID(inValid[0]), .IN_READY(inReady[0]),
    .EXEC_RD(execRd[0]), .JUMP_DEST(jumpDest[0]), .MEMORY_OUT(memoryOut[0]),
    .IN_RD_ADDR(inRdAddr[0]), .IN_RD_WE(inRdWe[0]), .IN_IS_LOAD(inIsLoad[0]),
    .IN_FUNCT3(inFunct3[0]), .IN_BYTE_SEL(inByteSel[0]),
    .WB_WE(wbWe[0]), .WB_ADDR(wbAddr[0]), .WB_DATA(wbData[0]), .PC(pc[0]),
    .RETIRE(retire[0]), .LOAD_ERR(loadErr[0]), .RETIRE_COUNT(retireCount[0])
  );

  writebacker #(.RESET_PC(RST_PC), .MEM_LATENCY(LAT1)) dut1 (
    .CLK(clk), .RST(rst[1]), .IN_VALID(inValid[1]), .IN_READY(inReady[1]),
    .EXEC_RD(execRd[1]), .JUMP_DEST(jumpDest[1]), .MEMORY_OUT(memoryOut[1]),
    .IN_RD_ADDR(inRdAddr[1]), .IN_RD_WE(inRdWe[1]), .IN_IS_LOAD(inIsLoad[1]),
    .IN_FUNCT3(inFunct3[1]), .IN_BYTE_SEL(inByteSel[1]),
    .WB_WE(wbWe[1]), .WB_ADDR(wbAddr[1]), .WB_DATA(wbData[1]), .PC(pc[1]),
    .RETIRE(retire[1]), .LOAD_ERR(loadErr[1]), .RETIRE_COUNT(retireCount[1])
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  // Loaded value computed with shifts and masks; signed results come from
  // subtracting 2^8 or 2^16 when the top bit of the field is set.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] sel,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(sel))) & 32'h0000_00FF;
    h = (w >> (16 * (int'(sel) / 2))) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b - 32'd256) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h0000_8000) ? (h - 32'h0001_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_bad_f3(input logic [2:0] f3);
    return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
  endfunction

  // Scribble random content on the instruction fields (IN_VALID untouched)
  task automatic drive_junk(input bit d);
    inIsLoad[d]  = 1'($urandom_range(0, 1));
    inFunct3[d]  = 3'($urandom_range(0, 7));
    inByteSel[d] = 2'($urandom_range(0, 3));
    inRdWe[d]    = 1'b1;
    inRdAddr[d]  = 5'($urandom_range(1, 31));
    execRd[d]    = $urandom;
    jumpDest[d]  = $urandom;
  endtask

  // Presents one instruction at the current negedge, lets it be accepted,
  // walks through the load wait (memory word only valid in the sampling
  // cycle) and checks the retire cycle. Returns at the negedge of the retire
  // cycle; with keepValid set IN_VALID stays high carrying junk fields.
  task automatic run_instr(input bit d, input logic isLoad, input logic [2:0] f3,
                           input logic [1:0] sel, input logic rdWe, input logic [4:0] rd,
                           input logic [31:0] exRd, input logic [31:0] jd,
                           input logic [31:0] mem, input logic keepValid, input string tag);
    int lat;
    logic err;
    logic we;
    logic [31:0] data;
    lat  = (d == 1'b0) ? LAT0 : LAT1;
    err  = isLoad && ref_bad_f3(f3);
    data = isLoad ? ref_load(f3, sel, mem) : exRd;
    we   = rdWe && (rd != 5'd0) && !err;

    inValid[d]   = 1'b1;
    inIsLoad[d]  = isLoad;
    inFunct3[d]  = f3;
    inByteSel[d] = sel;
    inRdWe[d]    = rdWe;
    inRdAddr[d]  = rd;
    execRd[d]    = exRd;
    jumpDest[d]  = jd;
    memoryOut[d] = $urandom;
    vectors++;
    if (inReady[d] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s ready_at_accept dut%0d got %b want 1", tag, d, inReady[d]);
    end
    @(posedge clk);
    @(negedge clk);
    inValid[d] = keepValid;
    drive_junk(d);

    if (isLoad) begin
      for (int j = 1; j <= lat; j++) begin
        memoryOut[d] = (j == lat) ? mem : $urandom;
        vectors++;
        if (inReady[d] !== 1'b0 || retire[d] !== 1'b0 || wbWe[d] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL %s load_wait dut%0d cycle %0d ready/retire/we got %b%b%b want 000",
                   tag, d, j, inReady[d], retire[d], wbWe[d]);
        end
        @(negedge clk);
      end
      memoryOut[d] = $urandom;
    end

    mCount[d] = mCount[d] + 32'd1;
    mPc[d]    = jd;
    if (we) begin
      mAddr[d] = rd;
      mData[d] = data;
    end

    vectors++;
    if (wbWe[d] !== we) begin
      miscompares++;
      $display("[TB] FAIL %s wb_we dut%0d got %b want %b", tag, d, wbWe[d], we);
    end
    vectors++;
    if (retire[d] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s retire dut%0d got %b want 1", tag, d, retire[d]);
    end
    vectors++;
    if (loadErr[d] !== err) begin
      miscompares++;
      $display("[TB] FAIL %s load_err dut%0d got %b want %b", tag, d, loadErr[d], err);
    end
    vectors++;
    if (pc[d] !== mPc[d]) begin
      miscompares++;
      $display("[TB] FAIL %s pc dut%0d got %h want %h", tag, d, pc[d], mPc[d]);
    end
    vectors++;
    if (retireCount[d] !== mCount[d]) begin
      miscompares++;
      $display("[TB] FAIL %s retire_count dut%0d got %h want %h", tag, d, retireCount[d], mCount[d]);
    end
    vectors++;
    if (wbAddr[d] !== mAddr[d]) begin
      miscompares++;
      $display("[TB] FAIL %s wb_addr dut%0d got %0d want %0d", tag, d, wbAddr[d], mAddr[d]);
    end
    vectors++;
    if (wbData[d] !== mData[d]) begin
      miscompares++;
      $display("[TB] FAIL %s wb_data dut%0d got %h want %h", tag, d, wbData[d], mData[d]);
    end
    vectors++;
    if (inReady[d] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s ready_after_retire dut%0d got %b want 1", tag, d, inReady[d]);
    end
  endtask

  // Runs idle cycles and checks that pulses are gone and everything holds
  task automatic test_idle(input bit d, input int cycles, input string tag);
    inValid[d] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      memoryOut[d] = $urandom;
      @(negedge clk);
      vectors++;
      if (wbWe[d] !== 1'b0 || retire[d] !== 1'b0 || loadErr[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s pulses dut%0d we/retire/err got %b%b%b want 000",
                 tag, d, wbWe[d], retire[d], loadErr[d]);
      end
      vectors++;
      if (wbAddr[d] !== mAddr[d] || wbData[d] !== mData[d] || pc[d] !== mPc[d] ||
          retireCount[d] !== mCount[d] || inReady[d] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL %s hold dut%0d addr/data/pc/count/ready got %0d/%h/%h/%h/%b want %0d/%h/%h/%h/1",
                 tag, d, wbAddr[d], wbData[d], pc[d], retireCount[d], inReady[d],
                 mAddr[d], mData[d], mPc[d], mCount[d]);
      end
    end
  endtask

  task automatic test_reset(input bit d);
    rst[d]     = 1'b1;
    inValid[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[d]    = 1'b0;
    mPc[d]    = RST_PC;
    mCount[d] = 32'd0;
    mAddr[d]  = 5'd0;
    mData[d]  = 32'd0;
    vectors++;
    if (pc[d] !== RST_PC) begin
      miscompares++;
      $display("[TB] FAIL reset_pc dut%0d got %h want %h", d, pc[d], RST_PC);
    end
    vectors++;
    if (retireCount[d] !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_count dut%0d got %h want 0", d, retireCount[d]);
    end
    vectors++;
    if (wbWe[d] !== 1'b0 || retire[d] !== 1'b0 || loadErr[d] !== 1'b0 || inReady[d] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl dut%0d we/retire/err/ready got %b%b%b%b want 0001",
               d, wbWe[d], retire[d], loadErr[d], inReady[d]);
    end
    vectors++;
    if (wbAddr[d] !== 5'd0 || wbData[d] !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_wb dut%0d addr/data got %0d/%h want 0/0", d, wbAddr[d], wbData[d]);
    end
  endtask

  task automatic test_nonload();
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd5, 32'h0000_1234, 32'h0000_0011, 32'd0, 1'b0, "nonload");
    test_idle(1'b0, 2, "nonload_pulse_drop");
  endtask

  task automatic test_back_to_back();
    test_reset(1'b0);
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd1, 32'hAAAA_0001, 32'h0000_0100, 32'd0, 1'b1, "b2b_0");
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd2, 32'hAAAA_0002, 32'h0000_0101, 32'd0, 1'b1, "b2b_1");
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd3, 32'hAAAA_0003, 32'h0000_0102, 32'd0, 1'b0, "b2b_2");
    vectors++;
    if (retireCount[0] !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL b2b_count got %0d want 3", retireCount[0]);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5];
    logic [1:0]  sels [5];
    logic [31:0] want [5];
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    sels = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    want = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) begin
        run_instr(1'(d), 1'b1, f3s[i], sels[i], 1'b1, 5'(i + 7), $urandom,
                  32'h0000_0200 + 32'(i), 32'h80FF_7F01, 1'b0, "load_table");
        vectors++;
        if (wbData[d] !== want[i]) begin
          miscompares++;
          $display("[TB] FAIL load_const dut%0d entry %0d got %h want %h", d, i, wbData[d], want[i]);
        end
      end
    end
  endtask

  task automatic test_mem_latency3();
    run_instr(1'b1, 1'b1, 3'b010, 2'd0, 1'b1, 5'd9, $urandom, 32'h0000_0300, 32'hC0DE_5EED, 1'b1, "lat3_lw");
    run_instr(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 5'd10, 32'h0BAD_F00D, 32'h0000_0301, 32'd0, 1'b0, "lat3_next");
  endtask

  task automatic test_x0();
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0000_0400, 32'd0, 1'b0, "x0_nonload");
    test_idle(1'b0, 1, "x0_hold");
    run_instr(1'b1, 1'b1, 3'b010, 2'd0, 1'b1, 5'd0, $urandom, 32'h0000_0401, 32'h1357_9BDF, 1'b0, "x0_load");
  endtask

  task automatic test_load_err();
    run_instr(1'b0, 1'b1, 3'b011, 2'd1, 1'b1, 5'd12, $urandom, 32'h0000_0500, 32'h1111_2222, 1'b0, "err_011");
    test_idle(1'b0, 1, "err_pulse_drop");
    run_instr(1'b1, 1'b1, 3'b110, 2'd2, 1'b1, 5'd13, $urandom, 32'h0000_0501, 32'h3333_4444, 1'b0, "err_110");
    run_instr(1'b0, 1'b1, 3'b111, 2'd0, 1'b1, 5'd14, $urandom, 32'h0000_0502, 32'h5555_6666, 1'b0, "err_111");
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        run_instr(1'(d), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                  (i != 29) ? 1'($urandom_range(0, 1)) : 1'b0, "random");
      end
      test_idle(1'(d), 1, "random_tail");
    end
  endtask

  task automatic test_count_wrap();
    force dut0.retireCount_q = 32'hFFFF_FFFE;
    #1;
    release dut0.retireCount_q;
    mCount[0] = 32'hFFFF_FFFE;
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd4, 32'h0000_00AA, 32'h0000_0600, 32'd0, 1'b1, "wrap_ff");
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd4, 32'h0000_00BB, 32'h0000_0601, 32'd0, 1'b1, "wrap_00");
    run_instr(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd4, 32'h0000_00CC, 32'h0000_0602, 32'd0, 1'b0, "wrap_01");
    vectors++;
    if (retireCount[0] !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL wrap_count got %h want 1", retireCount[0]);
    end
  endtask

  task automatic test_reset_in_wait();
    inValid[1]   = 1'b1;
    inIsLoad[1]  = 1'b1;
    inFunct3[1]  = 3'b010;
    inByteSel[1] = 2'd0;
    inRdWe[1]    = 1'b1;
    inRdAddr[1]  = 5'd20;
    execRd[1]    = $urandom;
    jumpDest[1]  = 32'h0000_0700;
    @(posedge clk);
    @(negedge clk);
    inValid[1] = 1'b0;
    vectors++;
    if (inReady[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstwait_enter ready got %b want 0", inReady[1]);
    end
    rst[1] = 1'b1;
    #1;
    vectors++;
    if (inReady[1] !== 1'b1 || pc[1] !== RST_PC || retireCount[1] !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rstwait_async ready/pc/count got %b/%h/%h want 1/%h/0",
               inReady[1], pc[1], retireCount[1], RST_PC);
    end
    @(negedge clk);
    rst[1]    = 1'b0;
    mPc[1]    = RST_PC;
    mCount[1] = 32'd0;
    mAddr[1]  = 5'd0;
    mData[1]  = 32'd0;
    test_idle(1'b1, 5, "rstwait_quiet");
    run_instr(1'b1, 1'b1, 3'b001, 2'd2, 1'b1, 5'd21, $urandom, 32'h0000_0710, 32'h9ABC_1234, 1'b0, "rstwait_after");
  endtask

  initial begin
    rst       = 2'b11;
    inValid   = '0;
    inRdWe    = '0;
    inIsLoad  = '0;
    execRd    = '0;
    jumpDest  = '0;
    memoryOut = '0;
    inRdAddr  = '0;
    inFunct3  = '0;
    inByteSel = '0;
    @(negedge clk);

    test_reset(1'b0);
    test_reset(1'b1);
    test_nonload();
    test_back_to_back();
    test_loads();
    test_mem_latency3();
    test_x0();
    test_load_err();
    test_random();
    test_count_wrap();
    test_reset_in_wait();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
